// File: rtl/uart_tx.sv
// uart_tx: even-parity UART transmitter (start, 8 data MSB-first, parity, stop) fed by a push FIFO.
// Define UART_TX_PARITY_INJECT_EN to add tx_bad_par, which inverts the parity bit of a queued byte.
module uart_tx #(
    parameter int CLKS_PER_BIT = 27,
    parameter int FIFO_DEPTH   = 4,
    parameter int PTR_W        = 2
) (
    input  logic             clk_3125,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_push,
`ifdef UART_TX_PARITY_INJECT_EN
    input  logic             tx_bad_par,
`endif
    output logic             tx_full,
    output logic [PTR_W:0]   tx_level,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

`ifdef UART_TX_PARITY_INJECT_EN
    localparam int DW = 9;
    logic [DW-1:0] wr_entry;
    assign wr_entry = {tx_bad_par, tx_data};
`else
    localparam int DW = 8;
    logic [DW-1:0] wr_entry;
    assign wr_entry = tx_data;
`endif

    logic [DW-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] level_q, level_d;
    logic [DW-1:0]  head;
    logic           push_ok, pop;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           tx_q, tx_d;
    logic           done_q, done_d;
    logic           last;
    logic           in_bit;

    assign tx_full  = level_q == (PTR_W+1)'(FIFO_DEPTH);
    assign tx_level = level_q;
    assign tx_busy  = state_q != IDLE;
    assign tx_done  = done_q;
    assign tx       = tx_q;
    assign state    = state_q;

    assign head    = mem_q[rd_ptr_q];
    assign push_ok = tx_push && !tx_full;
    assign pop     = state_q == LOAD;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk_3125) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign last   = cnt_q == 5'(CLKS_PER_BIT - 1);
    assign in_bit = state_q inside {START, DATA, PARITY, STOP};

    // tx is registered from the current state, so the line lags the state by one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = (in_bit && !last) ? cnt_q + 5'd1 : 5'd0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = 1'b1;
        done_d    = 1'b0;
        case (state_q)
            IDLE: state_d = (level_q != '0) ? LOAD : IDLE;
            LOAD: begin
                shift_d = head[7:0];
                par_d   = ^head;
                state_d = START;
            end
            START: begin
                tx_d      = 1'b0;
                bit_cnt_d = 3'd0;
                state_d   = last ? DATA : START;
            end
            DATA: begin
                tx_d = shift_q[7];
                if (last) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
            end
            PARITY: begin
                tx_d    = par_q;
                state_d = last ? STOP : PARITY;
            end
            STOP: begin
                done_d  = last;
                state_d = last ? ((level_q != '0) ? LOAD : IDLE) : STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_3125) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Even-parity UART transmitter; the upstream stage that drives the serial line consumed by the receiver in the same 3.125 MHz domain.
- Accepts bytes through a small push FIFO and serialises each byte as one 11-bit frame: start, 8 data MSB-first, even parity, stop.
- Bit order and parity rule match the receiver exactly, so a loopback returns the same byte on rx_msg.

Parameters:
CLKS_PER_BIT, 27, clock cycles per bit (115200 baud at 3.125 MHz); legal range 2..31.
FIFO_DEPTH, 4, byte FIFO depth; must be a power of 2, at least 2.
PTR_W, 2, FIFO pointer width; equals log2(FIFO_DEPTH).

Ports:
clk_3125  in  1  system clock, 3.125 MHz.
rst  in  1  synchronous reset, active-high.
tx_data  in  8  byte to send.
tx_push  in  1  write tx_data into the FIFO when tx_full=0.
tx_full  out  1  FIFO holds FIFO_DEPTH entries.
tx_level  out  PTR_W+1  FIFO occupancy, 0..FIFO_DEPTH.
tx_busy  out  1  high in every state except IDLE.
tx_done  out  1  one-cycle pulse when a frame's stop bit completes.
tx  out  1  serial line; idle level is high.
state  out  3  FSM state, for debug.

Behaviour:
- Reset, applied on a clock edge with rst=1:
  - tx=1, tx_busy=0, tx_done=0, tx_full=0, tx_level=0, state=IDLE.
  - FIFO pointers cleared; bit counter and cycle counter cleared.
  - A frame in progress is abandoned; tx is high from the next edge on.
- State encoding: IDLE=0, LOAD=1, START=2, DATA=3, PARITY=4, STOP=5. Codes 6 and 7 go to IDLE on the next edge.
- FIFO write:
  - tx_push with tx_full=0 writes one entry.
  - tx_push with tx_full=1 is dropped; FIFO contents and tx_level are unchanged.
  - A push and a pop in the same cycle leave tx_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- IDLE:
  - tx=1.
  - If tx_level is not 0, go to LOAD.
- LOAD (one cycle):
  - Pop the head entry into an 8-bit shift register.
  - Latch parity as the XOR of all 8 data bits (even parity).
  - tx=1; go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA:
  - tx = shift register bit 7; each bit is held for CLKS_PER_BIT cycles.
  - After each bit, shift left and increment the bit counter.
  - After the 8th bit, go to PARITY.
- PARITY:
  - tx = latched parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the edge that ends the stop bit, tx_done=1 for exactly one cycle.
  - Next state is LOAD if the FIFO is non-empty, otherwise IDLE.
- Latency: a push at edge E0 into an empty FIFO while IDLE gives tx=0 from edge E0+3.
- Frame length is 11*CLKS_PER_BIT = 297 cycles.
- Back-to-back frames have exactly one extra high cycle (LOAD) between the stop bit and the next start bit.
- The cycle counter is 5 bits, resets to 0 at each bit boundary, and does not wrap within a bit.
- tx is driven from a register, so it never glitches.
- tx_push during a frame never disturbs the frame already in the shift register.

Optional Feature:
- Macro: UART_TX_PARITY_INJECT_EN.
- When defined:
  - Adds input port tx_bad_par (1 bit), sampled together with tx_push and stored as a 9th FIFO bit.
  - For an entry with tx_bad_par=1, the transmitted parity bit is inverted, so the receiver outputs 0x3F.
- When undefined:
  - The port is absent, the FIFO is 8 bits wide, and parity is always correct.

Test Plan:
- Reset release, then push 0x41 -> tx sequence is 0 | 0 1 0 0 0 0 0 1 | 0 | 1, each bit 27 cycles; tx_done pulses once at cycle 297 after the start edge; tx_busy then falls.
- Push 0x07 -> data bits 0 0 0 0 0 1 1 1, parity bit 1; loopback into uart_rx gives rx_msg=0x07 with rx_complete.
- Push 0x11, 0x22, 0x33, 0x44, then 0x55 in 5 consecutive cycles while IDLE -> 0x11 is popped immediately, so all five are accepted and tx_full stays 0; a sixth push 0x66 the next cycle is dropped (tx_full=1, tx_level=4). Exactly five frames follow, each separated by one extra high cycle.
- Assert rst during DATA bit 4 of 0xA5 -> tx=1 and state=IDLE on the next edge; tx_level=0; no tx_done pulse; a later push of 0x3C transmits cleanly.
- FIFO at level 3 while mid-frame, push and pop land in the same cycle -> tx_level stays 3; data order is preserved across pointer wrap.
- With UART_TX_PARITY_INJECT_EN defined, push 0x41 with tx_bad_par=1 -> parity bit sent as 1; uart_rx outputs rx_msg=0x3F.
